// File: rtl/wb_arbiter2_if.sv
// Wishbone bundle for the two-master arbiter; signal names are seen from the arbiter.
// The arbiter uses the slave modport, and the environment (masters and slave) uses the master modport.
interface wb_arbiter2_if;
    logic [31:0] m0_data_i;
    logic [31:0] m0_addr_i;
    logic        m0_cyc_i;
    logic        m0_strobe_i;
    logic        m0_we_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;

    logic [31:0] m1_data_i;
    logic [31:0] m1_addr_i;
    logic        m1_cyc_i;
    logic        m1_strobe_i;
    logic        m1_we_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;

    logic [31:0] s_data_o;
    logic [31:0] s_addr_o;
    logic        s_cyc_o;
    logic        s_strobe_o;
    logic        s_we_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;

    modport slave (
        input  m0_data_i, m0_addr_i, m0_cyc_i, m0_strobe_i, m0_we_i,
        input  m1_data_i, m1_addr_i, m1_cyc_i, m1_strobe_i, m1_we_i,
        input  s_data_i, s_ack_i,
        output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        output s_data_o, s_addr_o, s_cyc_o, s_strobe_o, s_we_o
    );

    modport master (
        output m0_data_i, m0_addr_i, m0_cyc_i, m0_strobe_i, m0_we_i,
        output m1_data_i, m1_addr_i, m1_cyc_i, m1_strobe_i, m1_we_i,
        output s_data_i, s_ack_i,
        input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        input  s_data_o, s_addr_o, s_cyc_o, s_strobe_o, s_we_o
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of one slave. Defining WB_ARB_TIMEOUT_EN adds
// a stall watchdog driven by TIMEOUT_CYCLES and ERR_DATA, and a sticky timeout_o output.
module wb_arbiter2 #(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clock,
  input  logic              reset_n,
  wb_arbiter2_if.slave      bus,
  output logic [1:0]        grant_o
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  // Encoded so the state register doubles as the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic        tmo;

  logic        owner_cyc;
  logic        owner_stb;
  logic        owner_we;
  logic [31:0] owner_addr;
  logic [31:0] owner_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
          end else if (bus.m1_cyc_i) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
          end
        end
        OWN0:    if (!bus.m0_cyc_i || tmo) state_q <= IDLE;
        OWN1:    if (!bus.m1_cyc_i || tmo) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o = state_q;

  always_comb begin
    owner_cyc   = 1'b0;
    owner_stb   = 1'b0;
    owner_we    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    case (state_q)
      OWN0: begin
        owner_cyc   = bus.m0_cyc_i;
        owner_stb   = bus.m0_strobe_i;
        owner_we    = bus.m0_we_i;
        owner_addr  = bus.m0_addr_i;
        owner_wdata = bus.m0_data_i;
      end
      OWN1: begin
        owner_cyc   = bus.m1_cyc_i;
        owner_stb   = bus.m1_strobe_i;
        owner_we    = bus.m1_we_i;
        owner_addr  = bus.m1_addr_i;
        owner_wdata = bus.m1_data_i;
      end
      default: ;
    endcase
  end

  // Handshake: a beat is offered while cyc & strobe are high and completes in the cycle ack is
  // high; the owner keeps cyc up for the whole bus cycle, and dropping it releases the grant.
  assign bus.s_cyc_o    = owner_cyc & ~tmo;
  assign bus.s_strobe_o = owner_cyc & owner_stb & ~tmo;
  assign bus.s_we_o     = owner_we;
  assign bus.s_addr_o   = owner_addr;
  assign bus.s_data_o   = owner_wdata;

  assign bus.m0_ack_o = (state_q == OWN0) & (bus.s_ack_i | tmo);
  assign bus.m1_ack_o = (state_q == OWN1) & (bus.s_ack_i | tmo);

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       timeout_q;

  assign tmo = (state_q != IDLE) && owner_cyc && (cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (tmo) timeout_q <= 1'b1;
      if (state_q == IDLE || !owner_cyc || bus.s_ack_i || tmo) cnt_q <= '0;
      else if (owner_stb) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout_o     = timeout_q;
  assign bus.m0_data_o = (tmo && state_q == OWN0) ? ERR_DATA : bus.s_data_i;
  assign bus.m1_data_o = (tmo && state_q == OWN1) ? ERR_DATA : bus.s_data_i;
`else
  assign tmo           = 1'b0;
  assign bus.m0_data_o = bus.s_data_i;
  assign bus.m1_data_o = bus.s_data_i;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: per-cycle vector table plus hand-written reset and
// watchdog sequences, all compared through one expected-value queue.
module tb_wb_arbiter2;

  localparam int W = 135;

  logic       clock;
  logic       reset_n;
  logic [1:0] grant_o;
`ifdef WB_ARB_TIMEOUT_EN
  logic       timeout_o;
`endif

  wb_arbiter2_if bus();

  wb_arbiter2 #(.TIMEOUT_CYCLES(8'd8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .grant_o (grant_o)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  // Clock and reset.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One cycle of stimulus and the outputs expected while it is applied.
  // in: {c0,s0,w0,c1,s1,w1,ack}; o: {s_cyc,s_stb,m0_ack,m1_ack}; src: 0 none, 1 m0, 2 m1.
  typedef struct packed {
    logic [6:0] in;
    logic [1:0] g;
    logic [3:0] o;
    logic [1:0] src;
    logic       err;
  } vec_t;

  vec_t           tbl[$];
  logic [W-1:0]   exp_q[$];
  int             checks;
  int             errors;

  function automatic vec_t mk(input logic [6:0] in, input logic [1:0] g, input logic [3:0] o,
                              input logic [1:0] src, input logic err);
    vec_t v;
    v.in = in; v.g = g; v.o = o; v.src = src; v.err = err;
    return v;
  endfunction

  // Driver.
  task automatic drive(input vec_t v);
    bus.m0_cyc_i    = v.in[6];
    bus.m0_strobe_i = v.in[5];
    bus.m0_we_i     = v.in[4];
    bus.m1_cyc_i    = v.in[3];
    bus.m1_strobe_i = v.in[2];
    bus.m1_we_i     = v.in[1];
    bus.s_ack_i     = v.in[0];
    bus.m0_addr_i   = $urandom;
    bus.m0_data_i   = $urandom;
    bus.m1_addr_i   = $urandom;
    bus.m1_data_i   = $urandom;
    bus.s_data_i    = $urandom_range(32'hFFFF, 0);
  endtask

  // Expected outputs from the record and the values the bench itself drove.
  function automatic logic [W-1:0] exp_of(input vec_t v);
    logic [31:0] a, d, d0;
    logic        we;
    a = '0; d = '0; we = 1'b0;
    if (v.src == 2'd1) begin
      a = bus.m0_addr_i; d = bus.m0_data_i; we = v.in[4];
    end else if (v.src == 2'd2) begin
      a = bus.m1_addr_i; d = bus.m1_data_i; we = v.in[1];
    end
    d0 = v.err ? 32'hDEAD_BEEF : bus.s_data_i;
    return {v.g, v.o[3], v.o[2], we, v.o[1], v.o[0], a, d, d0, bus.s_data_i};
  endfunction

  // Scoreboard.
  task automatic check(input string name);
    logic [W-1:0] got, exp;
    got = {grant_o, bus.s_cyc_o, bus.s_strobe_o, bus.s_we_o, bus.m0_ack_o, bus.m1_ack_o,
           bus.s_addr_o, bus.s_data_o, bus.m0_data_o, bus.m1_data_o};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got=%h", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clock);
    drive(v);
    exp_q.push_back(exp_of(v));
    #2 check(name);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    int k;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(mk(7'b0, 2'b00, 4'b0, 2'd0, 1'b0));

    // Contested start after reset: m0 first, one dead cycle, then m1; stray ack dropped.
    tbl.push_back(mk(7'b111_110_0, 2'b00, 4'b0000, 2'd0, 1'b0));
    tbl.push_back(mk(7'b111_110_1, 2'b01, 4'b1110, 2'd1, 1'b0));
    tbl.push_back(mk(7'b001_110_0, 2'b01, 4'b0000, 2'd1, 1'b0));
    tbl.push_back(mk(7'b000_110_0, 2'b00, 4'b0000, 2'd0, 1'b0));
    tbl.push_back(mk(7'b000_110_1, 2'b10, 4'b1101, 2'd2, 1'b0));
    tbl.push_back(mk(7'b000_000_0, 2'b10, 4'b0000, 2'd2, 1'b0));
    tbl.push_back(mk(7'b000_000_1, 2'b00, 4'b0000, 2'd0, 1'b0));
    // Repeated contention: three single writes each, grants alternate m0, m1, ...
    for (int g = 0; g < 6; g++) begin
      k = g % 2;
      tbl.push_back(mk(7'b111_111_0, 2'b00, 4'b0000, 2'd0, 1'b0));
      tbl.push_back(mk(7'b111_111_1, (k == 0) ? 2'b01 : 2'b10,
                       (k == 0) ? 4'b1110 : 4'b1101, 2'(k + 1), 1'b0));
      tbl.push_back(mk((k == 0) ? 7'b001_111_0 : 7'b111_001_0,
                       (k == 0) ? 2'b01 : 2'b10, 4'b0000, 2'(k + 1), 1'b0));
    end
    // m1 four-beat burst while m0 waits; m0 served only after m1 releases.
    tbl.push_back(mk(7'b000_100_0, 2'b00, 4'b0000, 2'd0, 1'b0));
    for (int b = 0; b < 4; b++)
      tbl.push_back(mk(7'b110_110_1, 2'b10, 4'b1101, 2'd2, 1'b0));
    tbl.push_back(mk(7'b110_000_0, 2'b10, 4'b0000, 2'd2, 1'b0));
    tbl.push_back(mk(7'b110_000_0, 2'b00, 4'b0000, 2'd0, 1'b0));
    tbl.push_back(mk(7'b110_000_1, 2'b01, 4'b1110, 2'd1, 1'b0));
    tbl.push_back(mk(7'b000_000_0, 2'b01, 4'b0000, 2'd1, 1'b0));

    // Reset state, with requests and a slave ack present.
    step(mk(7'b110_110_1, 2'b00, 4'b0000, 2'd0, 1'b0), "reset_state");
    @(negedge clock);
    reset_n = 1'b1;
    drive(tbl[0]);
    exp_q.push_back(exp_of(tbl[0]));
    #2 check("vec_0");
    for (int i = 1; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec_%0d", i));

    // Reset mid-access: outputs drop at once, and the round-robin pointer restarts at m0.
    step(mk(7'b110_000_0, 2'b00, 4'b0000, 2'd0, 1'b0), "mid_req");
    step(mk(7'b110_000_1, 2'b01, 4'b1110, 2'd1, 1'b0), "mid_access");
    #1 reset_n = 1'b0;
    exp_q.push_back(exp_of(mk(7'b110_000_1, 2'b00, 4'b0000, 2'd0, 1'b0)));
    #1 check("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    drive(mk(7'b110_110_0, 2'b00, 4'b0000, 2'd0, 1'b0));
    exp_q.push_back(exp_of(mk(7'b110_110_0, 2'b00, 4'b0000, 2'd0, 1'b0)));
    #2 check("post_reset_idle");
    step(mk(7'b110_110_1, 2'b01, 4'b1110, 2'd1, 1'b0), "post_reset_m0_first");
    step(mk(7'b000_110_0, 2'b01, 4'b0000, 2'd1, 1'b0), "post_reset_release");
    step(mk(7'b000_000_0, 2'b00, 4'b0000, 2'd0, 1'b0), "post_reset_idle2");

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: watchdog answers at strobe+8 with the error word.
    step(mk(7'b110_000_0, 2'b00, 4'b0000, 2'd0, 1'b0), "wd_req");
    for (int c = 0; c < 8; c++)
      step(mk(7'b110_000_0, 2'b01, 4'b1100, 2'd1, 1'b0), $sformatf("wd_wait_%0d", c));
    step(mk(7'b110_000_0, 2'b01, 4'b0010, 2'd1, 1'b1), "wd_fire");
    check_bit("wd_flag_before", timeout_o, 1'b0);
    step(mk(7'b000_000_0, 2'b00, 4'b0000, 2'd0, 1'b0), "wd_idle");
    check_bit("wd_flag_set", timeout_o, 1'b1);
    step(mk(7'b000_000_0, 2'b00, 4'b0000, 2'd0, 1'b0), "wd_idle2");
    check_bit("wd_flag_sticky", timeout_o, 1'b1);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got=%0d exp=0 entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
